// File: rtl/apb_fabric_pkg.sv
// Shared definitions for the fabric-side APB3 initiator.
//   - apb_state_e : transfer FSM states (IDLE/SETUP/ACCESS/RESP)
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths
//   - RSP_* : response status encoding, packed as {err, timeout}
package apb_fabric_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Response status, bit 1 = error, bit 0 = error caused by timeout.
    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter for the APB ACCESS phase.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : synchronous clear (held while the FSM is in SETUP)
//   i_enable       : count one wait state
//   o_expired      : counter sits on the last permitted wait cycle
// TIMEOUT = 0 removes the counter entirely and ties o_expired low.
module apb_wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

            logic [CW-1:0] r_count;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_count <= '0;
                end else if (i_clear) begin
                    r_count <= '0;
                end else if (i_enable && (r_count != MAX)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Count value k means k wait states already seen, so the
            // (TIMEOUT)th ACCESS cycle is the one where the count is TIMEOUT-1.
            assign o_expired = (r_count == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_fabric_master.sv
// APB3 initiator driven by a simple command/response stream from fabric logic.
// Ports:
//   PCLK, PRESERN            : fabric clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake; cmd_write/cmd_addr/cmd_wdata
//   rsp_valid/rsp_ready      : response handshake; rsp_rdata/rsp_err/rsp_timeout
//   PSEL..PWDATA, PREADY..   : APB3 initiator interface
//   o_dbg_state              : current FSM state (apb_state_e encoding)
// Handshakes: a transfer on cmd_* or rsp_* happens on a rising PCLK edge where
// valid and ready are both high; the sender holds its payload stable while
// valid is high and ready is low, and ready never depends on valid.
module apb_fabric_master
    import apb_fabric_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 256
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PSLVERR,
    output logic [1:0]        o_dbg_state
);

    apb_state_e        r_state;
    apb_state_e        w_state_nxt;
    logic              r_ready_en;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [1:0]        r_rsp_status;

    logic w_psel;
    logic w_penable;
    logic w_idle;
    logic w_accept;
    logic w_done;
    logic w_abort;
    logic w_expired;

    // PREADY high on the timeout cycle completes normally.
    assign w_accept = cmd_valid && cmd_ready;
    assign w_done   = (r_state == ST_ACCESS) && PREADY;
    assign w_abort  = (r_state == ST_ACCESS) && !PREADY && w_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (PCLK),
        .i_rst_n   (PRESERN),
        .i_clear   (r_state == ST_SETUP),
        .i_enable  ((r_state == ST_ACCESS) && !PREADY),
        .o_expired (w_expired)
    );

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_idle      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                if (w_accept) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                w_psel      = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (w_done || w_abort) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Keeps cmd_ready low while reset is held even though the FSM idles.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_status <= RSP_OK;
        end else begin
            if (w_accept) begin
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                r_pwdata <= cmd_wdata;
            end
            if (w_done) begin
                r_rsp_rdata  <= r_pwrite ? '0 : PRDATA;
                r_rsp_status <= PSLVERR ? RSP_SLVERR : RSP_OK;
            end else if (w_abort) begin
                r_rsp_rdata  <= '0;
                r_rsp_status <= RSP_TIMEOUT;
            end
        end
    end

    assign cmd_ready   = w_idle && r_ready_en;
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_status[1];
    assign rsp_timeout = r_rsp_status[0];
    assign PSEL        = w_psel;
    assign PENABLE     = w_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_fabric_master.sv
module tb_apb_fabric_master;
    import apb_fabric_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic          PCLK = 1'b0;
    logic          PRESERN;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;
    logic [1:0]    dbg_state;

    always #5 PCLK = ~PCLK;

    apb_fabric_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESERN     (PRESERN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [DW+1:0]   exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One complete transfer: drives the command, plays the slave with the
    // requested number of wait states, then drains the response after
    // rsp_delay cycles of backpressure.
    task automatic run_xfer(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int waits,
                            input logic slverr, input logic [DW-1:0] rdata,
                            input int rsp_delay, input logic hold_valid);
        int            exp_acc;
        int            exp_lat;
        int            cyc;
        int            acc_cnt;
        logic          got_rsp;
        logic          tmo;
        logic [DW+1:0] exp_rsp;

        tmo     = (waits >= TO);
        exp_acc = tmo ? TO : waits + 1;
        exp_lat = 2 + exp_acc;
        if (tmo)     exp_rsp = {1'b1, 1'b1, {DW{1'b0}}};
        else if (wr) exp_rsp = {slverr, 1'b0, {DW{1'b0}}};
        else         exp_rsp = {slverr, 1'b0, rdata};
        exp_q.push_back(exp_rsp);

        @(negedge PCLK);
        PREADY  = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(posedge PCLK);

        cyc     = 1;
        acc_cnt = 0;
        got_rsp = 1'b0;
        while (cyc <= 40 && !got_rsp) begin
            @(negedge PCLK);
            if (hold_valid) begin
                cmd_write = ~wr;
                cmd_addr  = ~addr;
                cmd_wdata = ~wdata;
            end else begin
                cmd_valid = 1'b0;
            end
            check("cmd_ready_busy", cmd_ready, 0);
            if (rsp_valid) begin
                got_rsp = 1'b1;
                check("rsp_latency", cyc, exp_lat);
                check("apb_idle_in_resp", {PSEL, PENABLE}, 0);
            end else begin
                check("psel", PSEL, 1);
                check("paddr", PADDR, addr);
                check("pwdata", PWDATA, wdata);
                check("pwrite", PWRITE, wr);
                if (PENABLE) begin
                    PREADY  = (acc_cnt >= waits);
                    PSLVERR = PREADY ? slverr : 1'b1;
                    PRDATA  = PREADY ? rdata : DW'($urandom);
                    acc_cnt++;
                end else begin
                    check("setup_cycle", cyc, 1);
                    // Ready/error asserted during SETUP must be ignored.
                    PREADY  = 1'b1;
                    PSLVERR = 1'b1;
                    PRDATA  = DW'($urandom);
                end
                @(posedge PCLK);
                cyc++;
            end
        end
        check("rsp_seen_within_bound", got_rsp, 1);
        check("access_cycles", acc_cnt, exp_acc);

        PREADY  = 1'(($urandom_range(0, 1)));
        PSLVERR = 1'(($urandom_range(0, 1)));
        PRDATA  = DW'($urandom);

        for (int i = 0; i < rsp_delay; i++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_fields", {rsp_err, rsp_timeout, rsp_rdata}, exp_q[0]);
            check("cmd_ready_resp", cmd_ready, 0);
            check("no_psel_resp", PSEL, 0);
        end

        rsp_ready = 1'b1;
        check("rsp_fields", {rsp_err, rsp_timeout, rsp_rdata}, exp_q.pop_front());
        @(posedge PCLK);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_valid_cleared", rsp_valid, 0);
    endtask

    // Reset asserted during wait states of a read that would otherwise time out.
    task automatic reset_mid_access();
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;
        check("pre_reset_in_access", {PSEL, PENABLE}, 2'b11);
        #1;
        PRESERN = 1'b0;
        #1;
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge PCLK);
        PRESERN = 1'b1;
        PREADY  = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_no_rsp", rsp_valid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        PRESERN   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PREADY    = 1'b1;
        PRDATA    = '0;
        PSLVERR   = 1'b0;

        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_outputs",
              {cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, dbg_state}, 0);
        check("reset_rdata", rsp_rdata, 0);
        check("reset_paddr", PADDR, 0);
        check("reset_pwdata", PWDATA, 0);
        PRESERN = 1'b1;
        @(posedge PCLK);

        // zero-wait write
        run_xfer(1'b1, 32'h04, 32'h0000_01F4, 0, 1'b0, 32'h0, 0, 1'b0);
        // wait-state read
        run_xfer(1'b0, 32'h08, 32'h0, 3, 1'b0, 32'h0000_1234, 0, 1'b0);
        // slave error, then clean read
        run_xfer(1'b0, 32'h0C, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
        run_xfer(1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h5555_AAAA, 0, 1'b0);
        // timeout, and PREADY on the final permitted cycle
        run_xfer(1'b0, 32'h14, 32'h0, 20, 1'b0, 32'h0000_7777, 0, 1'b0);
        run_xfer(1'b1, 32'h18, 32'h0000_CAFE, TO - 1, 1'b0, 32'h0, 0, 1'b0);
        run_xfer(1'b0, 32'h1A, 32'h0, TO - 1, 1'b0, 32'h0000_0ABC, 0, 1'b0);
        // response backpressure with cmd_valid held high
        run_xfer(1'b1, 32'h1C, 32'h0000_A5A5, 1, 1'b1, 32'h0, 5, 1'b1);
        run_xfer(1'b0, 32'h20, 32'h0, 2, 1'b0, 32'h0BAD_F00D, 0, 1'b0);

        reset_mid_access();
        run_xfer(1'b0, 32'h44, 32'h0, 1, 1'b0, 32'h1357_9BDF, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            run_xfer(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                     $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)),
                     DW'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
